// File: rtl/ramio_arbiter_pkg.sv
// Shared types and constants for the ramio arbiter.
// FSM state encoding, port-count limit and the port-index width helper.
package ramio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int MAX_PORT_COUNT = 8;

  // Index width for a given port count; never below one bit so vectors stay legal.
  function automatic int port_index_width(input int port_count);
    return (port_count < 2) ? 1 : $clog2(port_count);
  endfunction

endpackage

// File: rtl/ramio_arbiter_picker.sv
// Combinational winner selection for the ramio arbiter.
// Default build: rotating priority starting at ptr, wrapping to port 0.
// With RAMIO_ARBITER_FIXED_PRIORITY_EN defined: lowest requesting index wins
// and ptr is ignored.
module ramio_arbiter_picker
  import ramio_arbiter_pkg::*;
#(
  parameter int PortCount         = 2,
  parameter int PortIndexBitWidth = port_index_width(PortCount)
) (
  input  logic [PortCount-1:0]         req,
  input  logic [PortIndexBitWidth-1:0] ptr,
  output logic [PortIndexBitWidth-1:0] winner,
  output logic                         valid
);

`ifdef RAMIO_ARBITER_FIXED_PRIORITY_EN

  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Scan from the top down so the lowest requesting index is the last to land.
  always_comb begin
    logic [PortIndexBitWidth-1:0] idx_w;
    winner = '0;
    valid  = 1'b0;
    idx_w  = '0;
    for (int i = PortCount - 1; i >= 0; i--) begin
      idx_w = i[PortIndexBitWidth-1:0];
      if (req[idx_w]) begin
        valid  = 1'b1;
        winner = idx_w;
      end
    end
  end

`else

  // First requester found scanning ptr, ptr+1, ... modulo PortCount.
  always_comb begin
    int                           idx;
    logic [PortIndexBitWidth-1:0] idx_w;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < PortCount; i++) begin
      idx = int'(ptr) + i;
      if (idx >= PortCount) idx = idx - PortCount;
      idx_w = idx[PortIndexBitWidth-1:0];
      if (!valid && req[idx_w]) begin
        valid  = 1'b1;
        winner = idx_w;
      end
    end
  end

`endif

endmodule

// File: rtl/ramio_arbiter.sv
// N-port arbiter sharing one ramio command interface between several masters.
// One transaction is outstanding downstream at a time; read data and
// completion are routed back to the issuing port.
// Build option: RAMIO_ARBITER_FIXED_PRIORITY_EN selects fixed priority
// (port 0 highest) instead of round-robin.
//
// Handshake: a master holds m_enable high with stable operands until it sees
// its one-cycle m_accept pulse; m_busy stays high from accept until the
// transaction completes; reads also pulse m_data_out_ready with m_data_out
// valid in that cycle. Downstream, s_enable is a one-cycle registered pulse
// launched only when s_busy was low; completion is s_data_out_ready for reads
// and s_busy low (from the second WAIT cycle) for writes.
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int PortCount       = 2,
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PortCount-1:0]                 m_enable,
  input  logic [PortCount*3-1:0]               m_read_type,
  input  logic [PortCount*2-1:0]               m_write_type,
  input  logic [PortCount*AddressBitWidth-1:0] m_address,
  input  logic [PortCount*DataBitWidth-1:0]    m_data_in,
  output logic [PortCount-1:0]                 m_accept,
  output logic [PortCount-1:0]                 m_busy,
  output logic [PortCount-1:0]                 m_data_out_ready,
  output logic [DataBitWidth-1:0]              m_data_out,
  output logic                                 s_enable,
  output logic [2:0]                           s_read_type,
  output logic [1:0]                           s_write_type,
  output logic [AddressBitWidth-1:0]           s_address,
  output logic [DataBitWidth-1:0]              s_data_in,
  input  logic [DataBitWidth-1:0]              s_data_out,
  input  logic                                 s_data_out_ready,
  input  logic                                 s_busy,
  output logic [1:0]                           dbg_state
);

  localparam int PortIndexBitWidth = port_index_width(PortCount);
  localparam logic [PortIndexBitWidth-1:0] LastPort = PortIndexBitWidth'(PortCount - 1);
  localparam logic [PortCount-1:0] OneHotBase = {{(PortCount-1){1'b0}}, 1'b1};

  state_e                       state;
  logic [PortIndexBitWidth-1:0] ptr;
  logic [PortIndexBitWidth-1:0] grant;
  logic                         grant_is_read;
  logic                         first_wait;

  logic [PortIndexBitWidth-1:0] pick_idx;
  logic                         pick_valid;
  logic [PortCount-1:0]         pick_onehot;
  logic [PortCount-1:0]         grant_onehot;
  logic [2:0]                   pick_read_type;

  assign pick_onehot    = OneHotBase << pick_idx;
  assign grant_onehot   = OneHotBase << grant;
  assign pick_read_type = m_read_type[pick_idx*3 +: 3];
  assign dbg_state      = state;

  ramio_arbiter_picker #(
    .PortCount         (PortCount),
    .PortIndexBitWidth (PortIndexBitWidth)
  ) u_picker (
    .req    (m_enable),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Arbitration FSM: latch a winner in IDLE, launch it in ISSUE, await completion in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= '0;
      grant            <= '0;
      grant_is_read    <= 1'b0;
      first_wait       <= 1'b0;
      m_accept         <= '0;
      m_busy           <= '0;
      m_data_out_ready <= '0;
      m_data_out       <= '0;
      s_enable         <= 1'b0;
      s_read_type      <= '0;
      s_write_type     <= '0;
      s_address        <= '0;
      s_data_in        <= '0;
    end else begin
      m_accept         <= '0;
      m_data_out_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant         <= pick_idx;
            grant_is_read <= |pick_read_type;
            s_read_type   <= pick_read_type;
            s_write_type  <= m_write_type[pick_idx*2 +: 2];
            s_address     <= m_address[pick_idx*AddressBitWidth +: AddressBitWidth];
            s_data_in     <= m_data_in[pick_idx*DataBitWidth +: DataBitWidth];
            m_accept      <= pick_onehot;
            m_busy        <= pick_onehot;
            // Launch immediately when ramio is already free.
            s_enable      <= ~s_busy;
            ptr           <= (pick_idx == LastPort) ? '0 : pick_idx + 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_enable) begin
            s_enable   <= 1'b0;
            first_wait <= 1'b1;
            state      <= WAIT;
          end else begin
            s_enable <= ~s_busy;
          end
        end
        WAIT: begin
          first_wait <= 1'b0;
          if (grant_is_read) begin
            if (s_data_out_ready) begin
              m_data_out       <= s_data_out;
              m_data_out_ready <= grant_onehot;
              m_busy           <= '0;
              state            <= IDLE;
            end
          end else if (!first_wait && !s_busy) begin
            // ramio only raises s_busy the cycle after s_enable, so skip the first cycle.
            m_busy <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramio_arbiter.sv
// Self-checking bench for ramio_arbiter with three ports and a small ramio model.
module tb_ramio_arbiter;

  localparam int PC = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [PC-1:0]     m_enable;
  logic [PC*3-1:0]   m_read_type;
  logic [PC*2-1:0]   m_write_type;
  logic [PC*AW-1:0]  m_address;
  logic [PC*DW-1:0]  m_data_in;
  logic [PC-1:0]     m_accept;
  logic [PC-1:0]     m_busy;
  logic [PC-1:0]     m_data_out_ready;
  logic [DW-1:0]     m_data_out;
  logic              s_enable;
  logic [2:0]        s_read_type;
  logic [1:0]        s_write_type;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_data_in;
  logic [DW-1:0]     s_data_out;
  logic              s_data_out_ready;
  logic              s_busy;
  logic [1:0]        dbg_state;

  ramio_arbiter #(.PortCount(PC), .AddressBitWidth(AW), .DataBitWidth(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m_enable         (m_enable),
    .m_read_type      (m_read_type),
    .m_write_type     (m_write_type),
    .m_address        (m_address),
    .m_data_in        (m_data_in),
    .m_accept         (m_accept),
    .m_busy           (m_busy),
    .m_data_out_ready (m_data_out_ready),
    .m_data_out       (m_data_out),
    .s_enable         (s_enable),
    .s_read_type      (s_read_type),
    .s_write_type     (s_write_type),
    .s_address        (s_address),
    .s_data_in        (s_data_in),
    .s_data_out       (s_data_out),
    .s_data_out_ready (s_data_out_ready),
    .s_busy           (s_busy),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [PC-1:0] exp_acc_q[$];
  logic [68:0]   exp_cmd_q[$];
  logic [34:0]   exp_rd_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int en_count    = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ramio model ----------------
  logic        init_busy;
  int          busy_len;
  logic [31:0] rd_data;
  logic        start_next;
  logic        cmd_rd;
  int          busy_cnt;

  initial begin
    s_busy = 1'b0;
    s_data_out_ready = 1'b0;
    s_data_out = 32'h0BAD0BAD;
    start_next = 1'b0;
    cmd_rd = 1'b0;
    busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_data_out_ready = 1'b0;
      s_data_out = 32'h0BAD0BAD;
      if (!rst_n) begin
        start_next = 1'b0;
        busy_cnt = 0;
        s_busy = 1'b0;
      end else begin
        if (start_next) begin
          start_next = 1'b0;
          busy_cnt = busy_len;
          s_busy = 1'b1;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            s_busy = init_busy;
            if (cmd_rd) begin
              s_data_out_ready = 1'b1;
              s_data_out = rd_data;
            end
          end
        end else begin
          s_busy = init_busy;
        end
        if (s_enable) begin
          start_next = 1'b1;
          cmd_rd = (s_read_type != 3'd0);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_sdr = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (m_accept != '0) begin
        if (exp_acc_q.size() == 0) check("acc_unexpected", m_accept, '0);
        else check("acc_port", m_accept, exp_acc_q.pop_front());
      end
      if (s_enable === 1'b1) begin
        en_count++;
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
        else check("cmd_fields", {s_read_type, s_write_type, s_address, s_data_in}, exp_cmd_q.pop_front());
      end
      if (m_data_out_ready != '0) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", m_data_out_ready, '0);
        else check("rd_port_data", {m_data_out_ready, m_data_out}, exp_rd_q.pop_front());
      end
      if ((m_data_out_ready != '0) || prev_sdr)
        check("rd_latency", {95'd0, m_data_out_ready != '0}, {95'd0, prev_sdr});
      if ((m_busy | m_accept) != '0)
        check("onehot", {94'd0, $onehot0(m_busy), $onehot0(m_accept)}, 96'd3);
      prev_sdr = s_data_out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic [2:0] rt, input logic [1:0] wt,
                          input logic [31:0] addr, input logic [31:0] data);
    m_read_type[p*3 +: 3]   = rt;
    m_write_type[p*2 +: 2]  = wt;
    m_address[p*AW +: AW]   = addr;
    m_data_in[p*DW +: DW]   = data;
  endtask

  task automatic push_txn(input int p, input logic [2:0] rt, input logic [1:0] wt,
                          input logic [31:0] addr, input logic [31:0] data,
                          input bit is_rd, input logic [31:0] rdata);
    logic [PC-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    exp_acc_q.push_back(oh);
    exp_cmd_q.push_back({rt, wt, addr, data});
    if (is_rd) exp_rd_q.push_back({oh, rdata});
  endtask

  task automatic wait_accept(input int p);
    bit ok;
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < 50) begin
      @(negedge clk);
      if (m_accept[p]) ok = 1'b1;
      c++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < 100) begin
      @(negedge clk);
      if (m_busy == '0) ok = 1'b1;
      c++;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_accept"}, m_accept, '0);
    check({tag, "_m_busy"}, m_busy, '0);
    check({tag, "_m_data_out_ready"}, m_data_out_ready, '0);
    check({tag, "_m_data_out"}, m_data_out, '0);
    check({tag, "_s_enable"}, s_enable, '0);
    check({tag, "_s_read_type"}, s_read_type, '0);
    check({tag, "_s_write_type"}, s_write_type, '0);
    check({tag, "_s_address"}, s_address, '0);
    check({tag, "_s_data_in"}, s_data_in, '0);
    check({tag, "_state"}, dbg_state, '0);
  endtask

  // ---------------- stimulus ----------------
  int rr_exp[5];
  int n;
  int held;
  int en_base;

  initial begin
    rst_n = 1'b0;
    m_enable = '0;
    m_read_type = '0;
    m_write_type = '0;
    m_address = '0;
    m_data_in = '0;
    init_busy = 1'b0;
    busy_len = 3;
    rd_data = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous requests from all three ports.
`ifdef RAMIO_ARBITER_FIXED_PRIORITY_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 0, 1};
`endif
    for (int p = 0; p < PC; p++) set_port(p, 3'd0, 2'b01, 32'h200 + 32'(p * 4), 32'hA000_0000 + 32'(p));
    for (int i = 0; i < 5; i++)
      push_txn(rr_exp[i], 3'd0, 2'b01, 32'h200 + 32'(rr_exp[i] * 4), 32'hA000_0000 + 32'(rr_exp[i]), 1'b0, 32'h0);
    m_enable = 3'b111;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clk);
      if (m_accept != '0) begin
        n++;
        if (n == 5) m_enable = '0;
      end
    end
    m_enable = '0;
    check("rr_accept_count", n, 5);
    wait_idle();

    // Single read from port 1.
    rd_data = 32'hDEADBEEF;
    busy_len = 3;
    set_port(1, 3'b001, 2'b00, 32'h100, 32'h0);
    push_txn(1, 3'b001, 2'b00, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    m_enable[1] = 1'b1;
    wait_accept(1);
    m_enable[1] = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("rd_data_held", m_data_out, 32'hDEADBEEF);

    // Write completion with a five-cycle busy window.
    busy_len = 5;
    set_port(0, 3'd0, 2'b01, 32'h40, 32'h12345678);
    push_txn(0, 3'd0, 2'b01, 32'h40, 32'h12345678, 1'b0, 32'h0);
    m_enable[0] = 1'b1;
    wait_accept(0);
    m_enable[0] = 1'b0;
    check("wr_enable_with_accept", s_enable, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("wr_busy_c%0d", k), m_busy[0], (k < 7) ? 1'b1 : 1'b0);
    end

    // Downstream busy when the request arrives.
    busy_len = 2;
    init_busy = 1'b1;
    rd_data = 32'h5555AAAA;
    repeat (2) @(negedge clk);
    set_port(2, 3'b010, 2'b10, 32'h8000, 32'hCAFE0002);
    push_txn(2, 3'b010, 2'b10, 32'h8000, 32'hCAFE0002, 1'b1, 32'h5555AAAA);
    en_base = en_count;
    m_enable[2] = 1'b1;
    @(negedge clk);
    check("busy_accept_cycle1", m_accept, 3'b100);
    m_enable[2] = 1'b0;
    held = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_enable) held++;
    end
    check("busy_hold_no_enable", held, 0);
    init_busy = 1'b0;
    wait_idle();
    check("busy_single_enable", en_count - en_base, 1);

    // Reset during a read in WAIT; pointer must restart at port 0.
    busy_len = 4;
    rd_data = 32'h77778888;
    set_port(0, 3'b001, 2'b00, 32'h300, 32'h0);
    push_txn(0, 3'b001, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
    m_enable[0] = 1'b1;
    wait_accept(0);
    m_enable[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    set_port(0, 3'd0, 2'b01, 32'h400, 32'h11110000);
    set_port(1, 3'd0, 2'b11, 32'h404, 32'h22220001);
    push_txn(0, 3'd0, 2'b01, 32'h400, 32'h11110000, 1'b0, 32'h0);
    push_txn(1, 3'd0, 2'b11, 32'h404, 32'h22220001, 1'b0, 32'h0);
    m_enable = 3'b011;
    for (int c = 0; c < 100 && m_enable != '0; c++) begin
      @(negedge clk);
      if (m_accept[0]) m_enable[0] = 1'b0;
      if (m_accept[1]) m_enable[1] = 1'b0;
    end
    check("post_reset_all_accepted", m_enable, '0);
    m_enable = '0;
    wait_idle();

    repeat (5) @(negedge clk);
    check("acc_queue_empty", exp_acc_q.size(), 0);
    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a wait above misbehaves.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
